// File: rtl/hack_alu_pkg.sv
// Shared definitions for the pipelined Hack ALU: control-word layout and
// the named opcodes the sequencer issues.
package hack_alu_pkg;

    localparam int CTRL_W  = 6;
    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    // Field order matches the bit indices above (zx is the MSB).
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } ctrl_t;

    localparam logic [CTRL_W-1:0] ADD   = 6'b000010;
    localparam logic [CTRL_W-1:0] AND   = 6'b000000;
    localparam logic [CTRL_W-1:0] OR    = 6'b010101;
    localparam logic [CTRL_W-1:0] NAND  = 6'b000001;
    localparam logic [CTRL_W-1:0] PASSX = 6'b001100;
    localparam logic [CTRL_W-1:0] NOTX  = 6'b011100;
    localparam logic [CTRL_W-1:0] ZERO  = 6'b101010;
    localparam logic [CTRL_W-1:0] ONE   = 6'b111111;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack-style ALU: zero/negate each operand, add or AND,
// optionally negate the result. Overflow is taken from the raw sum.
module hack_alu_core
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  out,
    output logic              zr,
    output logic              ng,
    output logic              ov
);

    logic [WIDTH-1:0] x1, x2, y1, y2, sum, o;

    assign x1  = ctrl[CTRL_ZX] ? '0 : x;
    assign x2  = ctrl[CTRL_NX] ? ~x1 : x1;
    assign y1  = ctrl[CTRL_ZY] ? '0 : y;
    assign y2  = ctrl[CTRL_NY] ? ~y1 : y1;
    assign sum = x2 + y2;
    assign o   = ctrl[CTRL_F] ? sum : (x2 & y2);
    assign out = ctrl[CTRL_NO] ? ~o : o;
    assign zr  = (out == '0);
    assign ng  = out[WIDTH-1];
    // Signed overflow of the add itself; the final inversion does not affect it.
    assign ov  = ctrl[CTRL_F] & (x2[WIDTH-1] == y2[WIDTH-1]) & (sum[WIDTH-1] != x2[WIDTH-1]);

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage Hack ALU pipeline: register file -> operand register (S1) ->
// ALU -> output register (S2), with writeback at the S1->S2 transfer and
// forwarding of that writeback into the op being accepted the same edge.
module hack_alu_pipe
    import hack_alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic              wb_en,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [WIDTH-1:0]  init_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zr,
    output logic              ng,
    output logic              ov,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  rf [DEPTH];

    logic              s1_valid;
    ctrl_t             s1_ctrl;
    logic [ADDR_W-1:0] s1_addr_d;
    logic              s1_wb_en;
    logic [WIDTH-1:0]  s1_x, s1_y;

    logic [WIDTH-1:0]  alu_out;
    logic              alu_zr, alu_ng, alu_ov;

    logic              s1_adv, accept, s1_wb;
    logic [WIDTH-1:0]  op_x, op_y;

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !init_we && (!s1_valid || s1_adv);
    assign accept   = in_valid && in_ready;
    assign s1_wb    = s1_adv && s1_wb_en;
    assign busy     = s1_valid | out_valid;

    // The op leaving S1 this edge writes the register file on the same edge,
    // so a dependent op being accepted must see the ALU output directly.
    assign op_x = (s1_wb && s1_addr_d == addr_a) ? alu_out : rf[addr_a];
    assign op_y = (s1_wb && s1_addr_d == addr_b) ? alu_out : rf[addr_b];

    hack_alu_core #(.WIDTH(WIDTH)) u_core (
        .x    (s1_x),
        .y    (s1_y),
        .ctrl (s1_ctrl),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .ov   (alu_ov)
    );

    // Register file: preload first, pipeline writeback last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else begin
            if (init_we) rf[init_addr] <= init_data;
            if (s1_wb)   rf[s1_addr_d] <= alu_out;
        end
    end

    // S1 operand register: load on accept, empty when its op moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_ctrl   <= '0;
            s1_addr_d <= '0;
            s1_wb_en  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_ctrl   <= ctrl_t'(ctrl);
            s1_addr_d <= addr_d;
            s1_wb_en  <= wb_en;
            s1_x      <= op_x;
            s1_y      <= op_y;
        end else if (s1_adv) begin
            s1_valid  <= 1'b0;
        end
    end

    // S2 output register: holds result and flags stable until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zr        <= 1'b0;
            ng        <= 1'b0;
            ov        <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            result    <= alu_out;
            zr        <= alu_zr;
            ng        <= alu_ng;
            ov        <= alu_ov;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Self-checking bench for hack_alu_pipe: a scoreboard of expected results is
// filled as ops are accepted and drained by a monitor on output handshakes.
module tb_hack_alu_pipe;
    import hack_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // 16-bit / 32-entry instance
    logic        in_valid, in_ready, wb_en, init_we, out_valid, out_ready;
    logic [5:0]  ctrl;
    logic [4:0]  addr_a, addr_b, addr_d, init_addr;
    logic [15:0] init_data, result;
    logic        zr, ng, ov, busy;

    // 8-bit / 8-entry instance
    logic        b_in_valid, b_in_ready, b_wb_en, b_init_we, b_out_valid, b_out_ready;
    logic [5:0]  b_ctrl;
    logic [2:0]  b_addr_a, b_addr_b, b_addr_d, b_init_addr;
    logic [7:0]  b_init_data, b_result;
    logic        b_zr, b_ng, b_ov, b_busy;

    hack_alu_pipe #(.WIDTH(16), .ADDR_W(5)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
        .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d), .wb_en(wb_en),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zr(zr), .ng(ng), .ov(ov), .busy(busy)
    );

    hack_alu_pipe #(.WIDTH(8), .ADDR_W(3)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .ctrl(b_ctrl),
        .addr_a(b_addr_a), .addr_b(b_addr_b), .addr_d(b_addr_d), .wb_en(b_wb_en),
        .init_we(b_init_we), .init_addr(b_init_addr), .init_data(b_init_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result),
        .zr(b_zr), .ng(b_ng), .ov(b_ov), .busy(b_busy)
    );

    typedef struct {
        logic [15:0] r;
        logic        zr;
        logic        ng;
        logic        ov;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   ncmp  = 0;
    int   nfail = 0;

    // Monitor: every output handshake pops and checks the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            ncmp++;
            if (sb.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_output: got r=%h with empty scoreboard", result);
            end else begin
                e = sb.pop_front();
                if ({result, zr, ng, ov} !== {e.r, e.zr, e.ng, e.ov}) begin
                    nfail++;
                    $display("FAIL %s: got r=%h zr=%b ng=%b ov=%b, want r=%h zr=%b ng=%b ov=%b",
                             e.nm, result, zr, ng, ov, e.r, e.zr, e.ng, e.ov);
                end
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        idle();
        init_we   = 1'b1;
        init_addr = a[4:0];
        init_data = d;
        @(posedge clk); #1;
        init_we   = 1'b0;
        @(posedge clk); #1;
    endtask

    // Present an op; waits (bounded) for in_ready and pushes the expectation on accept.
    task automatic issue(input logic [5:0] op, input int a, input int b, input int d, input logic wb,
                         input logic [15:0] er, input logic ezr, input logic eng, input logic eov,
                         input string nm, output int waits);
        in_valid = 1'b1;
        ctrl     = op;
        addr_a   = a[4:0];
        addr_b   = b[4:0];
        addr_d   = d[4:0];
        wb_en    = wb;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            ncmp++; nfail++;
            $display("FAIL %s_accept: in_ready=%b after %0d cycles, want 1", nm, in_ready, waits);
        end else begin
            sb.push_back('{er, ezr, eng, eov, nm});
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ncmp++;
        if (sb.size() != 0 || busy) begin
            nfail++;
            $display("FAIL %s_drain: pending=%0d busy=%b, want 0/0", nm, sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        init_we = 1'b0; out_ready = 1'b1;
        ctrl = '0; addr_a = '0; addr_b = '0; addr_d = '0; init_addr = '0; init_data = '0;
        b_in_valid = 1'b0; b_wb_en = 1'b0; b_init_we = 1'b0; b_out_ready = 1'b1;
        b_ctrl = '0; b_addr_a = '0; b_addr_b = '0; b_addr_d = '0; b_init_addr = '0; b_init_data = '0;
        #12;
        ncmp++;
        if ({out_valid, result, zr, ng, ov, busy} !== 21'd0) begin
            nfail++;
            $display("FAIL reset_hold: got v=%b r=%h zr=%b ng=%b ov=%b busy=%b, want all 0",
                     out_valid, result, zr, ng, ov, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        ncmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b busy=%b, want 1/0/0",
                     in_ready, out_valid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int w;
        preload(1, 16'h0001);
        preload(2, 16'h0002);
        issue(ADD, 1, 2, 3, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, "add_basic", w);
        idle();
        @(negedge clk);
        ncmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            nfail++;
            $display("FAIL latency_s1: got out_valid=%b busy=%b, want 0/1", out_valid, busy);
        end
        @(negedge clk);
        ncmp++;
        if (out_valid !== 1'b1 || result !== 16'h0003) begin
            nfail++;
            $display("FAIL latency_s2: got out_valid=%b r=%h, want 1/0003", out_valid, result);
        end
        wait_drain("basic");
        issue(PASSX, 3, 0, 0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, "r3_written", w);
        idle();
        wait_drain("basic_rd");
    endtask

    task automatic test_back_to_back();
        int w1, w2, w3;
        preload(3, 16'h0000);
        preload(4, 16'h0000);
        issue(ADD, 1, 2, 3, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, "b2b_first", w1);
        issue(ADD, 3, 1, 4, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, "b2b_fwd_x", w2);
        issue(ADD, 1, 4, 5, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, "b2b_fwd_y", w3);
        idle();
        ncmp++;
        if (w2 != 0 || w3 != 0) begin
            nfail++;
            $display("FAIL b2b_no_stall: got waits %0d/%0d, want 0/0", w2, w3);
        end
        wait_drain("b2b");
    endtask

    task automatic test_overflow();
        int w;
        preload(11, 16'h7FFF);
        preload(19, 16'h8000);
        issue(ADD, 11, 1, 6, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, "ovf_pos", w);
        issue(ADD, 11, 19, 6, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, "ovf_none", w);
        issue(ADD, 19, 19, 6, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "ovf_neg", w);
        idle();
        wait_drain("ovf");
    endtask

    task automatic test_logic();
        int w;
        preload(20, 16'h5555);
        preload(21, 16'hAAAA);
        issue(AND,   20, 21, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "and", w);
        issue(OR,    20, 21, 0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, "or", w);
        issue(ZERO,  20, 21, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "zero", w);
        issue(ONE,   20, 21, 0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, "one", w);
        issue(NAND,  20, 21, 0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, "nand", w);
        issue(NOTX,  20, 21, 0, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, "notx", w);
        issue(PASSX, 21, 20, 0, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, "passx", w);
        idle();
        wait_drain("logic");
    endtask

    task automatic test_backpressure();
        int w;
        out_ready = 1'b0;
        issue(PASSX, 20, 0, 0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, "bp_op1", w);
        issue(PASSX, 21, 0, 0, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, "bp_op2", w);
        // Third op must be refused while both stages are full.
        in_valid = 1'b1; ctrl = ADD; addr_a = 5'd1; addr_b = 5'd2; addr_d = 5'd0; wb_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ncmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 16'h5555) begin
                nfail++;
                $display("FAIL bp_stall%0d: got in_ready=%b out_valid=%b r=%h, want 0/1/5555",
                         i, in_ready, out_valid, result);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        sb.push_back('{16'h0003, 1'b0, 1'b0, 1'b0, "bp_op3"});
        @(negedge clk);
        ncmp++;
        if (in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL bp_release_ready: got in_ready=%b, want 1", in_ready);
        end
        @(posedge clk); #1;
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ncmp++;
            if (out_valid !== 1'b1) begin
                nfail++;
                $display("FAIL bp_drain%0d: got out_valid=%b, want 1", i, out_valid);
            end
        end
        wait_drain("bp");
    endtask

    task automatic test_preload_collision();
        int w;
        out_ready = 1'b1;
        issue(ADD, 1, 2, 8, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, "coll_add", w);
        // Writeback of r8 happens on the next edge, together with this preload.
        idle();
        init_we = 1'b1; init_addr = 5'd8; init_data = 16'hBEEF;
        @(negedge clk);
        ncmp++;
        if (in_ready !== 1'b0) begin
            nfail++;
            $display("FAIL ready_low_init: got in_ready=%b, want 0", in_ready);
        end
        @(posedge clk); #1;
        init_we = 1'b0;
        @(posedge clk); #1;
        wait_drain("coll");
        issue(PASSX, 8, 0, 0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, "pipe_wins", w);
        idle();
        wait_drain("coll_rd");
    endtask

    task automatic test_reset_midstream();
        int w;
        out_ready = 1'b0;
        issue(PASSX, 20, 0, 0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, "rm_op1", w);
        issue(ADD, 1, 2, 3, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, "rm_op2", w);
        idle();
        @(negedge clk);
        ncmp++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            nfail++;
            $display("FAIL rm_full: got out_valid=%b busy=%b, want 1/1", out_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        ncmp++;
        if ({out_valid, result, zr, ng, ov, busy} !== 21'd0) begin
            nfail++;
            $display("FAIL rm_async: got v=%b r=%h zr=%b ng=%b ov=%b busy=%b, want all 0",
                     out_valid, result, zr, ng, ov, busy);
        end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        issue(PASSX, 3, 0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "r3_not_written", w);
        issue(PASSX, 20, 0, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "rf_cleared", w);
        idle();
        wait_drain("rm");
    endtask

    task automatic test_width8();
        int n = 0;
        b_init_we = 1'b1; b_init_addr = 3'd1; b_init_data = 8'h7F;
        @(posedge clk); #1;
        b_init_addr = 3'd2; b_init_data = 8'h01;
        @(posedge clk); #1;
        b_init_we = 1'b0;
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_ctrl = ADD; b_addr_a = 3'd1; b_addr_b = 3'd2; b_addr_d = 3'd3; b_wb_en = 1'b1;
        @(negedge clk);
        ncmp++;
        if (b_in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL w8_ready: got in_ready=%b, want 1", b_in_ready);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_wb_en = 1'b0;
        @(negedge clk);
        while (!b_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        ncmp++;
        if ({b_out_valid, b_result, b_zr, b_ng, b_ov} !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b1}) begin
            nfail++;
            $display("FAIL w8_add_ovf: got v=%b r=%h zr=%b ng=%b ov=%b, want 1 80 0 1 1",
                     b_out_valid, b_result, b_zr, b_ng, b_ov);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_logic();
        test_backpressure();
        test_preload_collision();
        test_reset_midstream();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/hack_alu_pipe.md
Name: hack_alu_pipe

Overview:
- Parametrised, pipelined successor to the board-level Hack ALU: a register file with two read ports and one write port feeds a Hack-style six-bit ALU (zx nx zy ny f no).
- Two pipeline stages with valid/ready handshakes on both sides, optional writeback of the result into the register file, and a forwarding path for back-to-back dependent ops.
- Sits between the instruction sequencer and the display/debug logic.

Parameters:
- WIDTH, 16, datapath and register width in bits (at least 4).
- ADDR_W, 5, register-file address width; depth is 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  an op is presented.
- in_ready  out  1  the block accepts an op this cycle.
- ctrl  in  6  {zx,nx,zy,ny,f,no}.
- addr_a  in  ADDR_W  x operand register.
- addr_b  in  ADDR_W  y operand register.
- addr_d  in  ADDR_W  destination register.
- wb_en  in  1  write the result to addr_d.
- init_we  in  1  preload write strobe.
- init_addr  in  ADDR_W  preload address.
- init_data  in  WIDTH  preload data.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  ALU output.
- zr  out  1  result == 0.
- ng  out  1  result MSB.
- ov  out  1  signed overflow; meaningful only when f=1.
- busy  out  1  s1_valid | s2_valid.

Behaviour:
- Reset (asynchronous, active-high):
  - All register-file entries go to 0.
  - s1_valid=0 and out_valid=0; result, zr, ng and ov go to 0.
  - Reset asserted mid-operation drops in-flight ops; no writeback occurs.
- Stage S1 (operand register):
  - On in_valid&&in_ready, capture ctrl, addr_d, wb_en, and operands x=rf[addr_a], y=rf[addr_b] after forwarding.
  - Set s1_valid.
- Stage S2 (output register):
  - Loads from S1 when s1_adv = s1_valid && (!out_valid || out_ready).
  - Holds result, zr, ng, ov and out_valid.
  - Clears out_valid when out_ready is high and nothing advances.
- Ready and stall rules:
  - in_ready = !init_we && (!s1_valid || s1_adv). Fully combinational, no bubble when the downstream is ready.
  - Result and flags stay stable while out_valid && !out_ready.
- ALU (combinational, on S1 contents):
  - x1 = zx?0:x; x2 = nx?~x1:x1; same for y.
  - o = f ? x2+y2 (mod 2**WIDTH) : x2&y2; out = no ? ~o : o.
  - ov = f & (x2[MSB]==y2[MSB]) & (sum[MSB]!=x2[MSB]), computed before the `no` inversion; 0 when f=0.
- Writeback:
  - rf[s1.addr_d] <= ALU out on s1_adv when s1.wb_en. Writeback happens at S1→S2 transfer, not at output handshake.
- Forwarding:
  - At accept, if s1_adv && s1.wb_en && s1.addr_d==addr_a, x takes the ALU output instead of rf[addr_a]. Same rule for addr_b/y.
  - Otherwise the register-file value is used.
- Preload:
  - init_we writes rf[init_addr] <= init_data the same edge.
  - in_ready is low while init_we is high.
  - If a pipeline writeback hits the same address in the same cycle, the pipeline write wins.
  - Preload is not forwarded; the sequencer issues ops at least one cycle after init_we.
- Latency: accept at edge N → S1 at N → out_valid at N+1; throughput of 1 op/cycle.
- Address 0 is an ordinary register.

Decomposition:
- Package hack_alu_pkg holds:
  - ctrl bit indices, and a ctrl_t struct {zx,nx,zy,ny,f,no};
  - named opcode constants: ADD=000010, AND=000000, OR=010101, NAND=000001, PASSX=001100, NOTX=011100, ZERO=101010, ONE=111111.
- One combinational sub-module, hack_alu_core (WIDTH), produces out/zr/ng/ov. It is reused by the legacy top.

Test Plan:
- Preload r1=0x0001 and r2=0x0002, then issue ADD a=1 b=2 d=3 wb → result 0x0003, zr=0, ng=0, ov=0 one cycle after accept; r3 becomes 0x0003.
- Dependent back-to-back ops: ADD d=3 from r1,r2, then the next cycle ADD a=3 b=1 d=4 → second result 0x0004, proving forwarding; no stall cycle.
- Overflow: r11=0x7FFF and r1=0x0001, ADD → result 0x8000, ng=1, ov=1. Then r11=0x7FFF and r19=0x8000, ADD → 0xFFFF, ng=1, ov=0.
- Backpressure: hold out_ready=0 and issue 3 ops → 2 accepted and in_ready=0. Result stays stable. Release → results drain in order, one per cycle.
- Logic ops: r20=0x5555 and r21=0xAAAA → AND gives 0x0000 with zr=1; OR gives 0xFFFF with ng=1; ZERO gives 0x0000; ONE gives 0x0001.
- Reset mid-stream: assert rst while s1_valid=1 and out_valid=1 → outputs go to 0 immediately and r3 is not written. Re-run with WIDTH=8 and ADDR_W=3: ADD 0x7F+0x01 → 0x80, ov=1.
